// File: rtl/mem_buff_pkg.sv
// mem_buff_pkg: shared definitions for the dual-port addressable buffer.
//   - DEF_WIDTH / DEF_DEPTH / DEF_ADDR_W : default geometry
//   - cnt_w(depth)                       : width of an occupancy counter for 0..depth
//   - acc_err_t                          : per-cycle access error flags {range, empty_rd}
package mem_buff_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic range;
        logic empty_rd;
    } acc_err_t;

endpackage

// File: rtl/mem_buff_if.sv
// mem_buff_if: producer/consumer bus of the dual-port buffer.
//   master : drives wr_en/wr_addr/wr_data and rd_en/rd_addr, observes status
//   slave  : the buffer; drives rd_data, rd_valid, full_flag, empty_flag,
//            count, err_range, err_empty_rd
interface mem_buff_if
    import mem_buff_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_valid;
    logic                      full_flag;
    logic                      empty_flag;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      err_range;
    logic                      err_empty_rd;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, full_flag, empty_flag, count,
               err_range, err_empty_rd
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, full_flag, empty_flag, count,
               err_range, err_empty_rd
    );

endinterface

// File: rtl/mem_buff_occ.sv
// mem_buff_occ: valid-bit vector with registered occupancy count and
// full/empty flags for the dual-port buffer.
// Ports:
//   clk, rest           clock, synchronous active-high reset
//   set_i, set_idx_i    mark entry set_idx_i valid at this edge
//   clr_i, clr_idx_i    mark entry clr_idx_i invalid at this edge
//   valid_o             current valid bits
//   count_o             number of valid entries
//   full_o, empty_o     count_o == DEPTH / count_o == 0
// A set and a clear of the same index in one cycle leave the bit set.
module mem_buff_occ
    import mem_buff_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEF_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rest,
    input  logic                      set_i,
    input  logic [IDX_W-1:0]          set_idx_i,
    input  logic                      clr_i,
    input  logic [IDX_W-1:0]          clr_idx_i,
    output logic [DEPTH-1:0]          valid_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             inc, dec;

    always_comb begin
        valid_d = valid_q;
        // Only real bit transitions move the count; a same-index set+clear nets to nothing.
        inc = set_i && !valid_q[set_idx_i];
        dec = clr_i && valid_q[clr_idx_i] && !(set_i && (set_idx_i == clr_idx_i));
        if (clr_i) valid_d[clr_idx_i] = 1'b0;
        if (set_i) valid_d[set_idx_i] = 1'b1;

        count_d = count_q;
        if (inc && !dec && (count_q != CW'(DEPTH)))
            count_d = count_q + CW'(1);
        else if (dec && !inc && (count_q != '0))
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            valid_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign valid_o = valid_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/mem_buff_dp.sv
// mem_buff_dp: DEPTH x WIDTH addressable buffer with independent write and
// read ports, per-entry valid bits, registered read data (1-cycle latency),
// occupancy count, full/empty flags and illegal-access error pulses.
// Ports:
//   clk    rising-edge clock
//   rest   synchronous reset, active-high (valid bits and outputs only;
//          the data array is not cleared)
//   bus    mem_buff_if.slave: wr_en/wr_addr/wr_data, rd_en/rd_addr in;
//          rd_data, rd_valid, full_flag, empty_flag, count, err_range,
//          err_empty_rd out
// Reads of invalid entries return 0 and pulse err_empty_rd; accesses with
// address >= DEPTH are dropped and pulse err_range. A same-address write
// and read in one cycle returns the old contents.
// Configuration macro MEM_BUFF_CLR_ON_READ_EN: when defined, a successful
// read of a valid entry consumes it (clears its valid bit); a same-cycle
// write to that entry wins and keeps it valid.
module mem_buff_dp
    import mem_buff_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        rest,
    mem_buff_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_in, rd_in;
    logic             wr_ok, rd_ok;
    logic             rd_hit;
    logic             clr;

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    acc_err_t         err_q, err_d;

    logic [DEPTH-1:0] valid;
    logic [CW-1:0]    count;
    logic             full, empty;

    // Range check done at 32 bits so DEPTH == 2**ADDR_W does not truncate.
    assign wr_in  = (32'(bus.wr_addr) < 32'(DEPTH));
    assign rd_in  = (32'(bus.rd_addr) < 32'(DEPTH));
    assign wr_idx = bus.wr_addr[IDX_W-1:0];
    assign rd_idx = bus.rd_addr[IDX_W-1:0];
    assign wr_ok  = bus.wr_en && wr_in;
    assign rd_ok  = bus.rd_en && rd_in;
    assign rd_hit = valid[rd_idx];

`ifdef MEM_BUFF_CLR_ON_READ_EN
    assign clr = rd_ok && rd_hit;
`else
    assign clr = 1'b0;
`endif

    always_comb begin
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_ok;
        err_d        = '0;
        err_d.range  = (bus.wr_en && !wr_in) || (bus.rd_en && !rd_in);
        if (rd_ok) begin
            // mem is read before this edge's write lands: read-before-write.
            rd_data_d      = rd_hit ? mem[rd_idx] : '0;
            err_d.empty_rd = !rd_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Data array has no reset; stale contents are masked by the valid bits.
    always_ff @(posedge clk) begin
        if (!rest && wr_ok)
            mem[wr_idx] <= bus.wr_data;
    end

    mem_buff_occ #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_occ (
        .clk       (clk),
        .rest      (rest),
        .set_i     (wr_ok),
        .set_idx_i (wr_idx),
        .clr_i     (clr),
        .clr_idx_i (rd_idx),
        .valid_o   (valid),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.err_range    = err_q.range;
    assign bus.err_empty_rd = err_q.empty_rd;
    assign bus.count        = count;
    assign bus.full_flag    = full;
    assign bus.empty_flag   = empty;

endmodule

// File: tb/tb_mem_buff_dp.sv
module tb_mem_buff_dp;

    localparam int DEPTH = 8;

    logic clk  = 1'b0;
    logic rest = 1'b1;

    always #5 clk = ~clk;

    mem_buff_if #(.WIDTH(8), .DEPTH(8), .ADDR_W(4)) bus ();

    mem_buff_dp #(.WIDTH(8), .DEPTH(8), .ADDR_W(4)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents, valid flags and expected registered outputs.
    logic [7:0] m_mem   [DEPTH];
    bit         m_valid [DEPTH];
    logic [7:0] e_rd_data;
    logic       e_rd_valid;
    logic       e_err_range;
    logic       e_err_empty;
    int         e_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic re, input logic [3:0] ra);
        bit wr_in, rd_in;
        rest        = r;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            e_rd_data   = '0;
            e_rd_valid  = 1'b0;
            e_err_range = 1'b0;
            e_err_empty = 1'b0;
        end else begin
            wr_in       = we && (int'(wa) < DEPTH);
            rd_in       = re && (int'(ra) < DEPTH);
            e_err_range = (we && !wr_in) || (re && !rd_in);
            e_rd_valid  = rd_in;
            e_err_empty = 1'b0;
            if (rd_in) begin
                if (m_valid[ra]) begin
                    e_rd_data = m_mem[ra];
`ifdef MEM_BUFF_CLR_ON_READ_EN
                    m_valid[ra] = 1'b0;
`endif
                end else begin
                    e_rd_data   = '0;
                    e_err_empty = 1'b1;
                end
            end
            if (wr_in) begin
                m_mem[wa]   = wd;
                m_valid[wa] = 1'b1;
            end
        end
        e_count = 0;
        for (int i = 0; i < DEPTH; i++) e_count += int'(m_valid[i]);
        #1;
        chk("count",        32'(bus.count),      32'(e_count));
        chk("full_flag",    32'(bus.full_flag),  32'(e_count == DEPTH));
        chk("empty_flag",   32'(bus.empty_flag), 32'(e_count == 0));
        chk("rd_valid",     32'(bus.rd_valid),   32'(e_rd_valid));
        chk("rd_data",      32'(bus.rd_data),    32'(e_rd_data));
        chk("err_range",    32'(bus.err_range),  32'(e_err_range));
        chk("err_empty_rd", 32'(bus.err_empty_rd), 32'(e_err_empty));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic fill();
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 1'b1, 4'(i), 8'(i + 1), 1'b0, 4'd0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;

        // 1. reset, idle, read of an empty slot
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
        idle();
        chk("t1_empty", 32'(bus.empty_flag), 32'd1);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
        chk("t1_rd_data", 32'(bus.rd_data), 32'h00);
        chk("t1_err_empty", 32'(bus.err_empty_rd), 32'd1);

        // 2. fill then read back
        fill();
        chk("t2_count", 32'(bus.count), 32'd8);
        chk("t2_full", 32'(bus.full_flag), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i));
            chk("t2_rd_data", 32'(bus.rd_data), 32'(i + 1));
        end

        // 3. same-cycle write+read of addr 2 on a full buffer
        fill();
        cyc(1'b0, 1'b1, 4'd2, 8'hAA, 1'b1, 4'd2);
        chk("t3_old_data", 32'(bus.rd_data), 32'h03);
        chk("t3_count", 32'(bus.count), 32'd8);
        idle();
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd2);
        chk("t3_new_data", 32'(bus.rd_data), 32'hAA);

        // 4. out-of-range write and read
        fill();
        cyc(1'b0, 1'b1, 4'd9, 8'h5A, 1'b1, 4'd9);
        chk("t4_err_range", 32'(bus.err_range), 32'd1);
        chk("t4_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("t4_count", 32'(bus.count), 32'd8);

        // 5. read of addr 5 on a full buffer, then again
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
        chk("t5_rd_data", 32'(bus.rd_data), 32'h06);
        idle();
`ifdef MEM_BUFF_CLR_ON_READ_EN
        chk("t5_count", 32'(bus.count), 32'd7);
        chk("t5_full", 32'(bus.full_flag), 32'd0);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
        chk("t5_rd2", 32'(bus.rd_data), 32'h00);
        chk("t5_err_empty", 32'(bus.err_empty_rd), 32'd1);
`else
        chk("t5_count", 32'(bus.count), 32'd8);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
        chk("t5_rd2", 32'(bus.rd_data), 32'h06);
`endif

        // 6. reset with both ports active, then confirm the write was not committed
        cyc(1'b1, 1'b1, 4'd1, 8'h77, 1'b1, 4'd0);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_rd_data", 32'(bus.rd_data), 32'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd1);
        chk("t6_no_write", 32'(bus.rd_data), 32'h00);

        // randomized traffic, addresses partly out of range, occasional reset
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
